// File: rtl/write_arbiter_if.sv
// Write-path arbitration bundle: requests and selected-channel handshakes in,
// grant / route enables / status out.
interface write_arbiter_if;
    logic [2:0] awvalid_m;
    logic [3:0] awlen_sel;
    logic       awready_sel;
    logic       wvalid_sel;
    logic       wready_sel;
    logic       wlast_sel;
    logic       bvalid_sel;
    logic       bready_sel;
    logic [2:0] grant;
    logic       aw_en;
    logic       w_en;
    logic       b_en;
    logic       busy;
    logic       len_err;
    logic       timeout_err;

    // Master side drives requests and handshakes and observes the routing decision.
    modport master (
        output awvalid_m, awlen_sel, awready_sel,
        output wvalid_sel, wready_sel, wlast_sel,
        output bvalid_sel, bready_sel,
        input  grant, aw_en, w_en, b_en, busy, len_err, timeout_err
    );

    modport slave (
        input  awvalid_m, awlen_sel, awready_sel,
        input  wvalid_sel, wready_sel, wlast_sel,
        input  bvalid_sel, bready_sel,
        output grant, aw_en, w_en, b_en, busy, len_err, timeout_err
    );
endinterface

// File: rtl/write_arbiter.sv
// Round-robin owner of a shared AXI write path: one burst at a time through
// ADDR -> DATA -> RESP, with a watchdog that drops a stalled owner.
module write_arbiter #(
    parameter int NUM_M   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    write_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [3:0] awlen_q, awlen_d;
    logic [3:0] beat_q, beat_d;
    logic [7:0] wd_q, wd_d;
    logic       aw_en_q, aw_en_d, w_en_q, w_en_d, b_en_q, b_en_d, busy_q, busy_d;
    logic       len_err_q, len_err_d, timeout_err_q, timeout_err_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic [1:0] gidx;
    logic       aw_hs, w_hs, b_hs, expire;

    // Search starts one past the last served master, so it gets lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = 2'((int'(last_q) + k) % NUM_M);
            if (!win_found && bus.awvalid_m[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gidx = 2'd0;
        if (grant_q[1]) gidx = 2'd1;
        if (grant_q[2]) gidx = 2'd2;
    end

    assign aw_hs = (state_q == ADDR) && |(bus.awvalid_m & grant_q) && bus.awready_sel;
    assign w_hs  = (state_q == DATA) && bus.wvalid_sel && bus.wready_sel;
    assign b_hs  = (state_q == RESP) && bus.bvalid_sel && bus.bready_sel;
    // Any handshake on the active channel counts as progress and beats the watchdog.
    assign expire = (state_q != IDLE) && !(aw_hs || w_hs || b_hs) && (wd_q == WD_LIMIT);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        awlen_d       = awlen_q;
        beat_d        = beat_q;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: if (win_found) begin
                state_d = ADDR;
                grant_d = 3'b001 << win_idx;
            end
            ADDR: if (aw_hs) begin
                state_d = DATA;
                awlen_d = bus.awlen_sel;
                beat_d  = 4'd0;
            end
            DATA: if (w_hs) begin
                beat_d = beat_q + 4'd1;
                if (bus.wlast_sel) begin
                    state_d   = RESP;
                    len_err_d = (beat_q != awlen_q);
                end
            end
            RESP: if (b_hs) begin
                state_d = IDLE;
                grant_d = 3'b000;
                last_d  = gidx;
            end
            default: state_d = IDLE;
        endcase
        if (expire) begin
            state_d       = IDLE;
            grant_d       = 3'b000;
            last_d        = gidx;
            timeout_err_d = 1'b1;
        end

        if (state_q == IDLE || state_d != state_q || w_hs)
            wd_d = 8'd0;
        else
            wd_d = wd_q + 8'd1;

        aw_en_d = (state_d == ADDR);
        w_en_d  = (state_d == DATA);
        b_en_d  = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // Reset leaves last_q at M2 so the first search order is M0, M1, M2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= 3'b000;
            last_q        <= 2'd2;
            awlen_q       <= 4'd0;
            beat_q        <= 4'd0;
            wd_q          <= 8'd0;
            aw_en_q       <= 1'b0;
            w_en_q        <= 1'b0;
            b_en_q        <= 1'b0;
            busy_q        <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            awlen_q       <= awlen_d;
            beat_q        <= beat_d;
            wd_q          <= wd_d;
            aw_en_q       <= aw_en_d;
            w_en_q        <= w_en_d;
            b_en_q        <= b_en_d;
            busy_q        <= busy_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.aw_en       = aw_en_q;
    assign bus.w_en        = w_en_q;
    assign bus.b_en        = b_en_q;
    assign bus.busy        = busy_q;
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
